skinny_sbox8_inv_cms1_pipelined: RTL and testbench
==================================================

Name: skinny_sbox8_inv_cms1_pipelined

Overview:
- 2-share first-order CMS masked inverse of the SKINNY 8-bit S-box, for the decryption datapath of the masked SKINNY-128-384+ core.
- Computes the inverse as eight (x NOR y) XOR z gadgets over four register stages. Each gadget uses a refreshed ISW-style AND.
- Fully pipelined: accepts one masked byte per enabled cycle. A valid bit travels with the data.

Parameters:
- none (share count fixed at 2; randomness width fixed at 32)

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  pipeline advance; when low, every register holds
- vi  input  1  si0/si1 carry a valid byte this cycle
- si0  input  8  input share 0 (S-box output domain)
- si1  input  8  input share 1
- r  input  32  fresh randomness, sampled every enabled cycle
- vo  output  1  bo0/bo1 valid
- bo0  output  8  output share 0 (S-box input domain)
- bo1  output  8  output share 1

Behaviour:
- Unmasked function: bo0^bo1 = S8^-1(si0^si1). Notation: o = input byte, b = output byte, nor(x,y) = ~(x|y).
- Gadget g(x,y,z,r4):
  - x' = {x1, ~x0}, y' = {y1, ~y0}.
  - Register g0 = x'0&y'0^r0^r1, g1 = x'0&y'1^r1^r2, g2 = x'1&y'0^r2^r3, g3 = x'1&y'1^r3^r0.
  - z is registered alongside in the same cycle.
  - Output share 0 = g0^g1^z0; output share 1 = g2^g3^z1.
- Stage 1, from registered-free inputs:
  - b3 = nor(o7,o6)^o4, r[3:0]
  - b5 = nor(o6,o5)^o7, r[7:4]
  - b7 = nor(o2,o7)^o1, r[11:8]
  - b2 = nor(o3,o1)^o0, r[15:12]
- Stage 2: b1 = nor(o5,b3)^o3, r[19:16]; b0 = nor(b3,b2)^o5, r[23:20].
- Stage 3: b6 = nor(b2,b1)^o2, r[27:24].
- Stage 4: b4 = nor(b7,b6)^o6, r[31:28].
- Forwarding: both shares of every o bit and b bit needed later are carried in per-stage pipeline registers. Finished b bits are delayed to stage 4 so all eight emerge together.
  - Carry o5, o3, o2, o6 out of stage 1.
  - Carry b3 and b2 into stage 2, b2 and b1 into stage 3, b7 and b6 into stage 4.
  - Never recombine shares, and never place both shares of one variable in one combinational cone outside the gadget's cross-product registers.
- r slice binding: each slice is consumed in the cycle its gadget's AND registers capture. Consecutive bytes in flight therefore use disjoint r samples. r must be fresh every enabled cycle.
- Latency: exactly 4 enabled cycles. A byte presented with vi=1 on enabled edge k appears with vo=1 after enabled edge k+3, i.e. during the cycle after the 4th enabled edge.
- Throughput: 1 byte per enabled cycle.
- vi=0 is a bubble. Data registers still advance, but vo for that slot is 0. bo0/bo1 are don't-care but deterministic.
- en=0 freezes all data and valid registers, including gadget AND registers. On resume, outputs are identical to an uninterrupted run given the same r sequence per enabled cycle.
- Reset, synchronous, priority over en:
  - All valid bits, data shares and gadget registers go to 0, so vo=0, bo0=0x00, bo1=0x00 on the following cycle.
  - Reset mid-stream discards all bytes in flight, with no partial output.
- Simultaneous rst and vi: rst wins and the input is dropped.

Decomposition:
- Shared package skinny_sbox_pkg holds:
  - SBOX8_RAND_W = 32
  - SBOX8_INV_LAT = 4
  - r-slice index constants per inverse gadget
- One sub-module: cms1_sbox8_inv_gadget, i.e. gadget g above, with registered z and an en input.
  - The top instantiates it 8 times and owns the forwarding registers and the valid shift chain.

Test Plan:
- Known answers:
  - si0=0x65^0x3C, si1=0x3C, vi=1, en=1, random r → after 4 cycles vo=1, bo0^bo1=0x00.
  - Input 0xFF with any mask → 0xFF.
- Exhaustive: stream all 256 values back-to-back with random masks and random r each cycle → vo on 256 consecutive cycles starting cycle 4, and each unmasked output equals the inverse-table entry. Forward S8 then this block equals identity.
- Stall: stream 0x65, 0xFF, 0x4C with en toggling 1,0,0,1,1,0,1,1,1 → the same three results 0x00, 0xFF, 0x01 in order, with vo only on enabled cycles after the 4th enabled edge per byte.
- Bubbles: vi pattern 1,0,1,0 → vo pattern 1,0,1,0 delayed 4 cycles; no spurious vo.
- Reset mid-flight: assert rst one cycle after 3 valid inputs → next cycle vo=0, bo0=bo1=0x00; no stale vo within the following 4 cycles.
- Masking sanity: fixed unmasked input 0x00, 1000 runs with random masks and r → bo0 values are uniformly distributed, and bo0^bo1 is always 0x00.

Source files
------------

// File: rtl/skinny_sbox_pkg.sv
// Shared constants and share-carrying types for the masked SKINNY 8-bit S-box.
// A shared bit is packed as {share1, share0}.
package skinny_sbox_pkg;

  localparam int SBOX8_RAND_W  = 32;
  localparam int SBOX8_INV_LAT = 4;

  // Offset of each inverse gadget's 4-bit slice within r.
  localparam int RIDX_B3 = 0;
  localparam int RIDX_B5 = 4;
  localparam int RIDX_B7 = 8;
  localparam int RIDX_B2 = 12;
  localparam int RIDX_B1 = 16;
  localparam int RIDX_B0 = 20;
  localparam int RIDX_B6 = 24;
  localparam int RIDX_B4 = 28;

  typedef logic [1:0] shr_t;

  typedef struct packed {
    shr_t o6, o5, o3, o2;
  } fwd1_t;

  typedef struct packed {
    shr_t o6, o2, b7, b5, b3, b2;
  } fwd2_t;

  typedef struct packed {
    shr_t o6, b7, b5, b3, b2, b1, b0;
  } fwd3_t;

  typedef struct packed {
    shr_t b7, b6, b5, b3, b2, b1, b0;
  } fwd4_t;

endpackage

// File: rtl/skinny_sbox8_inv_cms1_pipelined_if.sv
// Datapath bundle of the masked inverse S-box: advance, masked byte in, masked byte out.
interface skinny_sbox8_inv_cms1_pipelined_if;
  import skinny_sbox_pkg::*;

  logic                    en;
  logic                    vi;
  logic [7:0]              si0;
  logic [7:0]              si1;
  logic [SBOX8_RAND_W-1:0] r;
  logic                    vo;
  logic [7:0]              bo0;
  logic [7:0]              bo1;

  modport master (output en, vi, si0, si1, r, input vo, bo0, bo1);
  modport slave  (input en, vi, si0, si1, r, output vo, bo0, bo1);

endinterface

// File: rtl/cms1_sbox8_inv_gadget.sv
// One CMS gadget computing (x NOR y) XOR z on two shares; the refreshed
// cross products and z are registered, and the shares are recombined after the register.
module cms1_sbox8_inv_gadget
  import skinny_sbox_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  shr_t       x,
  input  shr_t       y,
  input  shr_t       z,
  input  logic [3:0] r4,
  output shr_t       q
);

  logic [3:0] g_d, g_q;
  shr_t       z_d, z_q;
  logic       xp0, xp1, yp0, yp1;

  // Inverting share 0 turns the shared AND into a shared NOR.
  always_comb begin
    xp0    = ~x[0];
    xp1    = x[1];
    yp0    = ~y[0];
    yp1    = y[1];
    g_d[0] = (xp0 & yp0) ^ r4[0] ^ r4[1];
    g_d[1] = (xp0 & yp1) ^ r4[1] ^ r4[2];
    g_d[2] = (xp1 & yp0) ^ r4[2] ^ r4[3];
    g_d[3] = (xp1 & yp1) ^ r4[3] ^ r4[0];
    z_d    = z;
  end

  // NOTE: non-blocking assignments make every flop sample pre-edge values, so
  // stage ordering never depends on process scheduling.
  always_ff @(posedge clk) begin
    if (rst) begin
      g_q <= '0;
      z_q <= '0;
    end else if (en) begin
      g_q <= g_d;
      z_q <= z_d;
    end
  end

  assign q = {g_q[2] ^ g_q[3] ^ z_q[1], g_q[0] ^ g_q[1] ^ z_q[0]};

endmodule

// File: rtl/skinny_sbox8_inv_cms1_pipelined.sv
// First-order CMS masked inverse SKINNY 8-bit S-box, four register stages,
// one byte per enabled cycle; owns forwarding registers and the valid chain.
module skinny_sbox8_inv_cms1_pipelined
  import skinny_sbox_pkg::*;
(
  input logic                              clk,
  input logic                              rst,
  skinny_sbox8_inv_cms1_pipelined_if.slave bus
);

  shr_t [7:0] o;
  shr_t       b3, b5, b7, b2, b1, b0, b6, b4;

  fwd1_t s1_d, s1_q;
  fwd2_t s2_d, s2_q;
  fwd3_t s3_d, s3_q;
  fwd4_t s4_d, s4_q;
  logic [SBOX8_INV_LAT-1:0] vld_d, vld_q;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      o[i] = {bus.si1[i], bus.si0[i]};
    end
  end

  // Stage 1 works directly on the input shares.
  cms1_sbox8_inv_gadget u_g_b3 (.clk, .rst, .en(bus.en), .x(o[7]), .y(o[6]), .z(o[4]),
                                .r4(bus.r[RIDX_B3 +: 4]), .q(b3));
  cms1_sbox8_inv_gadget u_g_b5 (.clk, .rst, .en(bus.en), .x(o[6]), .y(o[5]), .z(o[7]),
                                .r4(bus.r[RIDX_B5 +: 4]), .q(b5));
  cms1_sbox8_inv_gadget u_g_b7 (.clk, .rst, .en(bus.en), .x(o[2]), .y(o[7]), .z(o[1]),
                                .r4(bus.r[RIDX_B7 +: 4]), .q(b7));
  cms1_sbox8_inv_gadget u_g_b2 (.clk, .rst, .en(bus.en), .x(o[3]), .y(o[1]), .z(o[0]),
                                .r4(bus.r[RIDX_B2 +: 4]), .q(b2));

  cms1_sbox8_inv_gadget u_g_b1 (.clk, .rst, .en(bus.en), .x(s1_q.o5), .y(b3), .z(s1_q.o3),
                                .r4(bus.r[RIDX_B1 +: 4]), .q(b1));
  cms1_sbox8_inv_gadget u_g_b0 (.clk, .rst, .en(bus.en), .x(b3), .y(b2), .z(s1_q.o5),
                                .r4(bus.r[RIDX_B0 +: 4]), .q(b0));

  cms1_sbox8_inv_gadget u_g_b6 (.clk, .rst, .en(bus.en), .x(s2_q.b2), .y(b1), .z(s2_q.o2),
                                .r4(bus.r[RIDX_B6 +: 4]), .q(b6));

  cms1_sbox8_inv_gadget u_g_b4 (.clk, .rst, .en(bus.en), .x(s3_q.b7), .y(b6), .z(s3_q.o6),
                                .r4(bus.r[RIDX_B4 +: 4]), .q(b4));

  // NOTE: every field is assigned on every pass through this block, so no
  // latch can be inferred for any next-state value.
  always_comb begin
    s1_d.o6 = o[6];
    s1_d.o5 = o[5];
    s1_d.o3 = o[3];
    s1_d.o2 = o[2];

    s2_d.o6 = s1_q.o6;
    s2_d.o2 = s1_q.o2;
    s2_d.b7 = b7;
    s2_d.b5 = b5;
    s2_d.b3 = b3;
    s2_d.b2 = b2;

    s3_d.o6 = s2_q.o6;
    s3_d.b7 = s2_q.b7;
    s3_d.b5 = s2_q.b5;
    s3_d.b3 = s2_q.b3;
    s3_d.b2 = s2_q.b2;
    s3_d.b1 = b1;
    s3_d.b0 = b0;

    s4_d.b7 = s3_q.b7;
    s4_d.b6 = b6;
    s4_d.b5 = s3_q.b5;
    s4_d.b3 = s3_q.b3;
    s4_d.b2 = s3_q.b2;
    s4_d.b1 = s3_q.b1;
    s4_d.b0 = s3_q.b0;

    vld_d = {vld_q[SBOX8_INV_LAT-2:0], bus.vi};
  end

  // NOTE: data shares are reset along with the valid bits so the outputs read
  // 0x00 after reset instead of leftover masked material from earlier bytes.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      s1_q  <= '0;
      s2_q  <= '0;
      s3_q  <= '0;
      s4_q  <= '0;
    end else if (bus.en) begin
      vld_q <= vld_d;
      s1_q  <= s1_d;
      s2_q  <= s2_d;
      s3_q  <= s3_d;
      s4_q  <= s4_d;
    end
  end

  assign bus.vo  = vld_q[SBOX8_INV_LAT-1];
  assign bus.bo0 = {s4_q.b7[0], s4_q.b6[0], s4_q.b5[0], b4[0],
                    s4_q.b3[0], s4_q.b2[0], s4_q.b1[0], s4_q.b0[0]};
  assign bus.bo1 = {s4_q.b7[1], s4_q.b6[1], s4_q.b5[1], b4[1],
                    s4_q.b3[1], s4_q.b2[1], s4_q.b1[1], s4_q.b0[1]};

endmodule

// File: tb/tb_skinny_sbox8_inv_cms1_pipelined.sv
// Scoreboard bench for the masked inverse S-box: expected bytes come from a
// forward S-box model inverted into a lookup table.
module tb_skinny_sbox8_inv_cms1_pipelined;

  typedef struct {
    logic [7:0] val;
    int         due;
  } exp_t;

  logic clk;
  logic rst;

  skinny_sbox8_inv_cms1_pipelined_if bus ();

  skinny_sbox8_inv_cms1_pipelined dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  int         en_edges = 0;
  exp_t       sb[$];
  logic [7:0] inv_tab [256];
  int         hist [256];
  int         ones [8];
  bit         collect = 1'b0;

  // Forward SKINNY S8 written as the algebraic inverse of the decryption circuit.
  function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
    logic [7:0] o;
    o[5] = b[0] ^ ~(b[3] | b[2]);
    o[3] = b[1] ^ ~(o[5] | b[3]);
    o[2] = b[6] ^ ~(b[2] | b[1]);
    o[6] = b[4] ^ ~(b[7] | b[6]);
    o[7] = b[5] ^ ~(o[6] | o[5]);
    o[4] = b[3] ^ ~(o[7] | o[6]);
    o[1] = b[7] ^ ~(o[2] | o[7]);
    o[0] = b[2] ^ ~(o[3] | o[1]);
    return o;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (enabled edge %0d)", tag, got, exp, en_edges);
    end
  endtask

  task automatic monitor();
    logic exp_vo;
    exp_t e;
    exp_vo = (sb.size() > 0) && (sb[0].due == en_edges);
    check("vo", 32'(bus.vo), 32'(exp_vo));
    if (exp_vo) begin
      e = sb.pop_front();
      check("unmasked", 32'(bus.bo0 ^ bus.bo1), 32'(e.val));
      if (collect) begin
        hist[bus.bo0]++;
        for (int i = 0; i < 8; i++) ones[i] += int'(bus.bo0[i]);
      end
    end
  endtask

  // Drive one cycle with a fresh mask and fresh r, then observe 1 ns after the edge.
  task automatic step(input logic en_i, input logic vi_i, input logic [7:0] o_i);
    logic [7:0] m;
    exp_t       e;
    m       = 8'($urandom);
    bus.en  = en_i;
    bus.vi  = vi_i;
    bus.si0 = o_i ^ m;
    bus.si1 = m;
    bus.r   = $urandom;
    if (en_i && vi_i && !rst) begin
      e.val = inv_tab[o_i];
      e.due = en_edges + 4;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      sb.delete();
    end else if (en_i) begin
      en_edges++;
      monitor();
    end
  endtask

  task automatic flush(input int n);
    repeat (n) step(1'b1, 1'b0, 8'($urandom));
  endtask

  initial begin
    logic [7:0] stall_bytes [3];
    bit         en_pat [9];
    int         nb;
    int         distinct;

    stall_bytes = '{8'h65, 8'hFF, 8'h4C};
    en_pat      = '{1, 0, 0, 1, 1, 0, 1, 1, 1};
    for (int b = 0; b < 256; b++) begin
      inv_tab[sbox_fwd(8'(b))] = 8'(b);
      hist[b] = 0;
    end
    for (int i = 0; i < 8; i++) ones[i] = 0;

    rst     = 1'b1;
    bus.en  = 1'b0;
    bus.vi  = 1'b0;
    bus.si0 = '0;
    bus.si1 = '0;
    bus.r   = '0;
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    check("rst_vo",  32'(bus.vo),  32'(0));
    check("rst_bo0", 32'(bus.bo0), 32'(0));
    check("rst_bo1", 32'(bus.bo1), 32'(0));
    rst = 1'b0;

    // Known answers
    step(1'b1, 1'b1, 8'h65);
    step(1'b1, 1'b1, 8'hFF);
    step(1'b1, 1'b1, 8'hFF);
    flush(4);

    // Forward S8 of every byte streamed back-to-back must come back as the byte
    for (int b = 0; b < 256; b++) step(1'b1, 1'b1, sbox_fwd(8'(b)));
    flush(4);

    // Stall pattern; frozen cycles present junk with vi=1 that must be ignored
    nb = 0;
    for (int i = 0; i < 9; i++) begin
      if (en_pat[i] && nb < 3) begin
        step(1'b1, 1'b1, stall_bytes[nb]);
        nb++;
      end else begin
        step(1'(en_pat[i]), 1'b1 & ~1'(en_pat[i]), 8'($urandom));
      end
    end
    flush(4);

    // Bubbles
    step(1'b1, 1'b1, 8'h4C);
    step(1'b1, 1'b0, 8'h65);
    step(1'b1, 1'b1, 8'h65);
    step(1'b1, 1'b0, 8'h4C);
    flush(4);

    // Reset mid-flight, asserted with en low and vi high
    step(1'b1, 1'b1, 8'h12);
    step(1'b1, 1'b1, 8'h34);
    step(1'b1, 1'b1, 8'h56);
    rst = 1'b1;
    step(1'b0, 1'b1, 8'h78);
    rst = 1'b0;
    check("midrst_vo",  32'(bus.vo),  32'(0));
    check("midrst_bo0", 32'(bus.bo0), 32'(0));
    check("midrst_bo1", 32'(bus.bo1), 32'(0));
    flush(4);

    // Masking sanity on a fixed unmasked input
    collect = 1'b1;
    repeat (1000) step(1'b1, 1'b1, 8'h00);
    flush(4);
    collect = 1'b0;
    distinct = 0;
    for (int b = 0; b < 256; b++) if (hist[b] > 0) distinct++;
    check("bo0_spread", 32'(distinct >= 200), 32'(1));
    for (int i = 0; i < 8; i++) check("bo0_bit_balance", 32'(ones[i] >= 380 && ones[i] <= 620), 32'(1));
    check("sb_drained", 32'(sb.size()), 32'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
